// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Receives a program image over an 8N1 UART line and writes it word by word
//   into port B of the unified instruction/data memory. The CPU core is held
//   in reset until the whole image has been written.
//
//   Image format: SYNC_BYTE, LEN_LO, LEN_HI (N = 16-bit word count), then
//   4*N data bytes. Each word is little-endian: its first byte lands in
//   bits 7:0.
//
//   Optional feature, enabled by defining BOOT_CHECKSUM_EN:
//     One trailing byte follows the last word, or follows LEN_HI when N = 0.
//     It must equal the XOR of all 4*N data bytes. A match ends in DONE; a
//     mismatch ends in ERROR.
//
//   Ports
//     sysclk      system clock; all logic uses the rising edge
//     rst         asynchronous active-high reset
//     uart_rx     asynchronous serial input; idles high, LSB first
//     mem_addr    word address for memory port B
//     mem_wdata   assembled write word
//     mem_we      4'hF for exactly one cycle per word, 4'h0 otherwise
//     cpu_rst     reset to the CPU core; stays high until DONE
//     boot_done   sticky; the image loaded successfully
//     boot_error  sticky; a framing, length or checksum error occurred
//     busy        high from sync byte accepted until DONE or ERROR
//
//   Handshake: the RX front end produces single-cycle byte_valid and
//   framing_err strobes. There is no backpressure; the FSM consumes every
//   strobe in the cycle it occurs. The FSM state is held in the 'state'
//   register, and rx_state holds the receiver state, for debug and checkers.
module uart_boot_loader #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         ADDR_WIDTH   = 13,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_we,
  output logic                  cpu_rst,
  output logic                  boot_done,
  output logic                  boot_error,
  output logic                  busy
);

  localparam int          CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

  // ---------------------------------------------------------------- RX
  typedef enum logic [1:0] {RX_WAIT_START, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       rx_state;
  logic            rx_s1, rx_s2, rx_prev;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic [7:0]      rx_byte;
  logic            byte_valid;
  logic            framing_err;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_prev     <= 1'b1;
      rx_state    <= RX_WAIT_START;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      rx_byte     <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      rx_s1       <= uart_rx;
      rx_s2       <= rx_s1;
      rx_prev     <= rx_s2;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      case (rx_state)
        RX_WAIT_START: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          // Re-check the line at the middle of the start bit. A line that has
          // gone high again was only a glitch.
          if (rx_cnt == HALF_BIT) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_WAIT_START : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == FULL_BIT) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin // RX_STOP
          if (rx_cnt == FULL_BIT) begin
            rx_cnt   <= '0;
            rx_byte  <= rx_shift;
            if (rx_s2) byte_valid  <= 1'b1;
            else       framing_err <= 1'b1;
            rx_state <= RX_WAIT_START;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- loader
  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_WRITE, ST_CHK, ST_DONE, ST_ERROR
  } state_t;

  state_t                state;
  logic [7:0]            len_lo;
  logic [15:0]           len;
  logic [ADDR_WIDTH:0]   word_idx;
  logic [1:0]            byte_idx;
  logic [31:0]           word_reg;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]            chk;
`endif

  logic [15:0] n_words;
  logic        word_last;
  assign n_words   = {rx_byte, len_lo};
  assign word_last = (32'(word_idx) + 32'd1) == 32'(len);

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      len_lo     <= '0;
      len        <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word_reg   <= '0;
`ifdef BOOT_CHECKSUM_EN
      chk        <= '0;
`endif
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 4'h0;
      cpu_rst    <= 1'b1;
      boot_done  <= 1'b0;
      boot_error <= 1'b0;
      busy       <= 1'b0;
    end else begin
      mem_we <= 4'h0;
      case (state)
        ST_IDLE: begin
          if (byte_valid && rx_byte == SYNC_BYTE) begin
            state <= ST_LEN_LO;
            busy  <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
            chk   <= '0;
`endif
          end
        end
        ST_LEN_LO: begin
          if (framing_err) begin
            state <= ST_ERROR; boot_error <= 1'b1; busy <= 1'b0;
          end else if (byte_valid) begin
            len_lo <= rx_byte;
            state  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (framing_err) begin
            state <= ST_ERROR; boot_error <= 1'b1; busy <= 1'b0;
          end else if (byte_valid) begin
            len <= n_words;
            if (n_words == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
              state <= ST_CHK;
`else
              state <= ST_DONE; boot_done <= 1'b1; cpu_rst <= 1'b0; busy <= 1'b0;
`endif
            end else if (32'(n_words) > MAX_WORDS) begin
              state <= ST_ERROR; boot_error <= 1'b1; busy <= 1'b0;
            end else begin
              word_idx <= '0;
              byte_idx <= '0;
              state    <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (framing_err) begin
            state <= ST_ERROR; boot_error <= 1'b1; busy <= 1'b0;
          end else if (byte_valid) begin
            // Bytes enter at the top and move down, so after four bytes the
            // first one sits in bits 7:0.
            word_reg <= {rx_byte, word_reg[31:8]};
            byte_idx <= byte_idx + 1'b1;
`ifdef BOOT_CHECKSUM_EN
            chk      <= chk ^ rx_byte;
`endif
            if (byte_idx == 2'd3) begin
              mem_we    <= 4'hF;
              mem_addr  <= word_idx[ADDR_WIDTH-1:0];
              mem_wdata <= {rx_byte, word_reg[31:8]};
              state     <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          word_idx <= word_idx + 1'b1;
          if (framing_err) begin
            state <= ST_ERROR; boot_error <= 1'b1; busy <= 1'b0;
          end else if (word_last) begin
`ifdef BOOT_CHECKSUM_EN
            state <= ST_CHK;
`else
            state <= ST_DONE; boot_done <= 1'b1; cpu_rst <= 1'b0; busy <= 1'b0;
`endif
          end else begin
            state <= ST_DATA;
          end
        end
`ifdef BOOT_CHECKSUM_EN
        ST_CHK: begin
          if (framing_err || (byte_valid && rx_byte != chk)) begin
            state <= ST_ERROR; boot_error <= 1'b1; busy <= 1'b0;
          end else if (byte_valid) begin
            state <= ST_DONE; boot_done <= 1'b1; cpu_rst <= 1'b0; busy <= 1'b0;
          end
        end
`endif
        ST_DONE: begin
          cpu_rst <= 1'b0;
        end
        default: begin // ST_ERROR; ST_CHK is unreachable without the checksum
          cpu_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader
//   Directed bench for uart_boot_loader with CLKS_PER_BIT = 16. A protocol
//   model turns each sent image into expected memory writes (exp_q) and an
//   expected final outcome. A compare process checks every mem_we cycle
//   against exp_q. Literal expectations pin the model.
module tb_uart_boot_loader;

  localparam int CPB = 16;
  localparam int AW  = 13;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          sysclk = 1'b0;
  logic          rst    = 1'b1;
  logic          uart_rx = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_we;
  logic          cpu_rst, boot_done, boot_error, busy;

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .SYNC_BYTE(SYNC)) dut (
    .sysclk(sysclk), .rst(rst), .uart_rx(uart_rx),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cpu_rst(cpu_rst), .boot_done(boot_done), .boot_error(boot_error), .busy(busy)
  );

  // ---------------------------------------------------------------- clock/reset
  always #5 sysclk = ~sysclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [AW+31:0] exp_q[$];
  logic [7:0]     img[$];
  bit             exp_done, exp_error;
  logic [AW-1:0]  last_addr = '0;
  logic [31:0]    last_wdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Protocol model: find the sync byte, read the length, then emit one write
  // per complete group of four bytes.
  task automatic model_img(input bit frame_err);
    int i, n, k;
    logic [7:0]  x;
    logic [31:0] w;
    i = 0; x = 8'h00;
    exp_done = 1'b0; exp_error = 1'b0;
    while (i < img.size() && img[i] != SYNC) i++;
    n = int'(img[i+1]) + 256 * int'(img[i+2]);
    i += 3;
    if (n > (1 << AW)) begin
      exp_error = 1'b1;
      return;
    end
    for (k = 0; k < n && i + 3 < img.size(); k++) begin
      w = {img[i+3], img[i+2], img[i+1], img[i]};
      x = x ^ img[i] ^ img[i+1] ^ img[i+2] ^ img[i+3];
      exp_q.push_back({AW'(k), w});
      i += 4;
    end
    if (k == n) begin
`ifdef BOOT_CHECKSUM_EN
      if (i < img.size()) begin
        exp_done  = (img[i] == x);
        exp_error = !exp_done;
      end
`else
      exp_done = 1'b1;
`endif
    end
    if (!exp_done && !exp_error && frame_err) exp_error = 1'b1;
  endtask

  // Compare process: every write strobe must match the head of exp_q.
  always @(negedge sysclk) begin
    if (!rst) begin
      if (mem_we !== 4'h0) begin
        check("mem_we_value", 64'(mem_we), 64'hF);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", mem_addr, mem_wdata);
        end else begin
          logic [AW+31:0] e;
          e = exp_q.pop_front();
          check("mem_addr", 64'(mem_addr), 64'(e[AW+31:32]));
          check("mem_wdata", 64'(mem_wdata), 64'(e[31:0]));
        end
        last_addr  <= mem_addr;
        last_wdata <= mem_wdata;
      end
      if (cpu_rst === boot_done) begin
        n_checks++;
        n_fail++;
        $display("FAIL cpu_rst_vs_done: cpu_rst %0b boot_done %0b", cpu_rst, boot_done);
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(negedge sysclk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge sysclk);
    end
    uart_rx = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(negedge sysclk);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge sysclk);
  endtask

  task automatic send_img();
    for (int i = 0; i < img.size(); i++) send_byte(img[i], 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    repeat (3) @(negedge sysclk);
  endtask

  task automatic check_outcome(input string name);
    repeat (8) @(negedge sysclk);
    check({name, "_done"},  64'(boot_done),  64'(exp_done));
    check({name, "_error"}, 64'(boot_error), 64'(exp_error));
    check({name, "_cpu_rst"}, 64'(cpu_rst), 64'(!exp_done));
    check({name, "_busy"}, 64'(busy), 64'(!exp_done && !exp_error));
    check({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_cpu_rst"},    64'(cpu_rst),    64'd1);
    check({name, "_mem_we"},     64'(mem_we),     64'd0);
    check({name, "_mem_addr"},   64'(mem_addr),   64'd0);
    check({name, "_mem_wdata"},  64'(mem_wdata),  64'd0);
    check({name, "_boot_done"},  64'(boot_done),  64'd0);
    check({name, "_boot_error"}, 64'(boot_error), 64'd0);
    check({name, "_busy"},       64'(busy),       64'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    repeat (3) @(negedge sysclk);
    check_reset_values("reset");
    rst = 1'b0;
    repeat (3) @(negedge sysclk);

    // Single word.
    img = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef BOOT_CHECKSUM_EN
    img.push_back(8'h08);
`endif
    model_img(1'b0);
    for (int i = 0; i < 3; i++) send_byte(img[i], 1'b0);
    repeat (4) @(negedge sysclk);
    check("t1_busy_after_header", 64'(busy), 64'd1);
    check("t1_cpu_rst_after_header", 64'(cpu_rst), 64'd1);
    for (int i = 3; i < img.size(); i++) send_byte(img[i], 1'b0);
    check_outcome("t1");
    check("t1_wdata_literal", 64'(last_wdata), 64'h12345678);
    check("t1_addr_literal", 64'(last_addr), 64'h0);
    check("t1_done_literal", 64'(boot_done), 64'd1);

    // Leading junk, then two words.
    do_reset();
    img = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h02, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef BOOT_CHECKSUM_EN
    img.push_back(8'h88);
`endif
    model_img(1'b0);
    send_img();
    check_outcome("t2");
    check("t2_wdata_literal", 64'(last_wdata), 64'h88776655);
    check("t2_addr_literal", 64'(last_addr), 64'h1);

    // Zero-length image.
    do_reset();
    img = '{8'hA5, 8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
    img.push_back(8'h00);
`endif
    model_img(1'b0);
    send_img();
    check_outcome("t3");
    check("t3_done_literal", 64'(boot_done), 64'd1);

    // Framing error mid-word; later traffic must be ignored.
    do_reset();
    img = '{8'hA5, 8'h01, 8'h00, 8'hAA};
    model_img(1'b1);
    send_img();
    send_byte(8'hBB, 1'b1);
    img = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_img();
    check_outcome("t4");
    check("t4_error_literal", 64'(boot_error), 64'd1);

    // Length one past the address space.
    do_reset();
    img = '{8'hA5, 8'h01, 8'h20};
    model_img(1'b0);
    send_img();
    check_outcome("t5");
    check("t5_error_literal", 64'(boot_error), 64'd1);

    // Reset in the middle of the third data byte, then a full reload.
    do_reset();
    img = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
    model_img(1'b0);
    send_img();
    fork
      send_byte(8'h33, 1'b0);
      begin
        repeat (80) @(negedge sysclk);
        rst = 1'b1;
        @(negedge sysclk);
        check_reset_values("t6_mid_reset");
      end
    join
    rst = 1'b0;
    repeat (3) @(negedge sysclk);
    check("t6_no_writes_before_reset", 64'(exp_q.size()), 64'd0);
    img = '{8'hA5, 8'h02, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef BOOT_CHECKSUM_EN
    img.push_back(8'h88);
`endif
    model_img(1'b0);
    send_img();
    check_outcome("t6");

`ifdef BOOT_CHECKSUM_EN
    // Correct trailer.
    do_reset();
    img = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    model_img(1'b0);
    send_img();
    check_outcome("t7");
    check("t7_done_literal", 64'(boot_done), 64'd1);

    // Wrong trailer: the word is written, then ERROR.
    do_reset();
    img = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    model_img(1'b0);
    send_img();
    check_outcome("t8");
    check("t8_error_literal", 64'(boot_error), 64'd1);
    check("t8_wdata_literal", 64'(last_wdata), 64'h04030201);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Upstream of the CPU core: receives a program image over a UART RX line and writes it word-by-word into port B of the unified instruction/data memory.
- Holds the core in reset (drives cpu_rst) until the image is complete, then releases it so the core fetches from address 0.
- Terminal states: DONE (core runs) or ERROR (core stays in reset); leaving either requires rst.

Parameters:
- CLKS_PER_BIT, 868, sysclk cycles per UART bit (100 MHz / 115200); must be >= 4.
- ADDR_WIDTH, 13, word address width of memory port B.
- SYNC_BYTE, 8'hA5, image start marker.

Ports:
- sysclk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- uart_rx  input  1  asynchronous serial input, 8N1, LSB first, idle high.
- mem_addr  output  ADDR_WIDTH  word address for memory port B.
- mem_wdata  output  32  write data, little-endian assembled word.
- mem_we  output  4  byte write enables; 4'hF for one cycle per word, else 4'h0.
- cpu_rst  output  1  reset to CPU core; 1 until DONE.
- boot_done  output  1  image loaded successfully; sticky.
- boot_error  output  1  framing, length or checksum error; sticky.
- busy  output  1  high from sync byte accepted until DONE/ERROR.

Behaviour:
- Reset values: cpu_rst=1, mem_we=0, mem_addr=0, mem_wdata=0, boot_done=0, boot_error=0, busy=0; FSM in IDLE; RX in WAIT_START.
- RX front end: 2-FF synchroniser on uart_rx. Falling edge starts a half-bit count (CLKS_PER_BIT/2); if the line is still 0, the start bit is valid, else return to WAIT_START (glitch rejection). Data bits are sampled every CLKS_PER_BIT at bit centre. Stop bit sampled at centre: 1 -> byte_valid pulse (1 cycle); 0 -> framing_err pulse.
- Protocol: SYNC_BYTE, LEN_LO, LEN_HI (N = word count, 16 bit), then 4N data bytes, each word little-endian (first byte -> bits 7:0).
- FSM states and transitions:
  - IDLE: non-SYNC bytes and framing errors are ignored. On SYNC -> LEN_LO, busy=1.
  - LEN_LO -> LEN_HI on byte.
  - LEN_HI on byte: N=0 -> DONE (or CHK if macro is set); N > 2^ADDR_WIDTH -> ERROR; else -> DATA with word index = 0 and byte index = 0.
  - DATA: shift byte into word register. After the 4th byte -> WRITE.
  - WRITE: exactly one cycle with mem_we=4'hF, mem_addr=word index, mem_wdata=assembled word. Then word index increments. Last word -> DONE (or CHK); else -> DATA.
  - DONE: boot_done=1, cpu_rst=0, busy=0; all further RX traffic ignored.
  - ERROR: boot_error=1, cpu_rst=1, busy=0; all further RX traffic ignored.
- A framing error in any state except IDLE/DONE/ERROR -> ERROR.
- Latency: mem_we pulse starts the cycle after byte_valid of the 4th byte. cpu_rst falls in the same cycle boot_done rises.
- mem_addr and mem_wdata hold their last values outside WRITE.
- Word index width is ADDR_WIDTH+1 so N = 2^ADDR_WIDTH is legal with no wrap.
- Reset mid-operation: immediate abort to reset values. Words already written stay in memory. A subsequent full image reloads normally.

Optional Feature:
- Macro BOOT_CHECKSUM_EN.
- Defined: after the last word (or after LEN_HI when N=0), state CHK waits for one extra byte. The byte must equal the XOR of all 4N data bytes; match -> DONE, mismatch -> ERROR.
- Not defined: no CHK state, no trailing byte; boot_error is set only by framing or length errors.

Test Plan:
- CLKS_PER_BIT=16. Send A5 01 00 78 56 34 12 -> single mem_we=4'hF pulse, mem_addr=0, mem_wdata=32'h12345678; then boot_done=1, cpu_rst=0.
- Send 00 FF 3C, then A5 02 00 + 8 bytes (11 22 33 44 55 66 77 88) -> leading bytes ignored; writes addr0=32'h44332211, addr1=32'h88776655; done.
- Send A5 00 00 -> no mem_we pulse; boot_done=1 (macro off).
- Send A5 01 00 AA, then a frame with stop bit 0 -> boot_error=1, cpu_rst=1, no write; later valid bytes are ignored.
- Assert rst during the 3rd data byte of a 2-word image -> all outputs return to reset values; resending the full image completes with correct writes.
- Macro on: A5 01 00 01 02 03 04 + 04 -> done. Same image with trailer 05 -> boot_error=1 after the write of 32'h04030201.
